// File: rtl/tetris_pkg.sv
// Shared command/state types, HID usage codes and the keycode-to-command map.
// KEYCODE_ARROWS_EN: when defined, arrow keys map alongside WASD.
package tetris_pkg;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_LEFT   = 3'd1,
    CMD_RIGHT  = 3'd2,
    CMD_ROTATE = 3'd3,
    CMD_SOFT   = 3'd4,
    CMD_HARD   = 3'd5
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DAS     = 3'd1,
    ST_REPEAT  = 3'd2,
    ST_SOFTREP = 3'd3,
    ST_HOLD    = 3'd4
  } key_state_t;

  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_RIGHT = 8'h4F;
  localparam logic [7:0] HID_UP    = 8'h52;
  localparam logic [7:0] HID_DOWN  = 8'h51;

  function automatic cmd_t map_keycode(input logic [7:0] kc);
    cmd_t m;
    m = CMD_NONE;
    case (kc)
      HID_A:     m = CMD_LEFT;
      HID_D:     m = CMD_RIGHT;
      HID_W:     m = CMD_ROTATE;
      HID_S:     m = CMD_SOFT;
      HID_SPACE: m = CMD_HARD;
`ifdef KEYCODE_ARROWS_EN
      HID_LEFT:  m = CMD_LEFT;
      HID_RIGHT: m = CMD_RIGHT;
      HID_UP:    m = CMD_ROTATE;
      HID_DOWN:  m = CMD_SOFT;
`endif
      default:   m = CMD_NONE;
    endcase
    return m;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/keycode_cmd_gen_if.sv
// Command valid/ready channel from keycode_cmd_gen to game_logic.
interface keycode_cmd_gen_if;
  import tetris_pkg::*;

  logic cmd_valid;
  logic cmd_ready;
  cmd_t cmd;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/keycode_cmd_gen_das_timer.sv
// Loadable up-counter that saturates at limit; expire is high while running at limit.
module das_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         run,
  input  logic [W-1:0] limit,
  output logic         expire
);
  logic [W-1:0] count;

  // load starts at 1 so the load cycle itself counts toward the interval
  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (load)      count <= W'(1);
    else if (run && (count != limit)) count <= count + W'(1);
  end

  assign expire = run && (count == limit);
endmodule

// File: rtl/keycode_cmd_gen.sv
// Keycode level to one-shot/auto-repeat move commands over valid/ready.
// Arrow-key mapping is enabled by KEYCODE_ARROWS_EN (see tetris_pkg).
//
// state      | meaning
// IDLE       | no mapped key held
// DAS        | left/right held, waiting for first auto-repeat
// REPEAT     | left/right auto-repeating every ARR_CYCLES
// SOFTREP    | soft drop repeating every SOFT_CYCLES
// HOLD       | rotate/hard held, no repeats
module keycode_cmd_gen
  import tetris_pkg::*;
#(
  parameter int DAS_CYCLES  = 8_333_333,
  parameter int ARR_CYCLES  = 2_500_000,
  parameter int SOFT_CYCLES = 1_250_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               keycode,
  keycode_cmd_gen_if.master        cmd_if,
  output logic                     held
);
  localparam int TW = $clog2(max3(DAS_CYCLES, ARR_CYCLES, SOFT_CYCLES) + 1);

  logic [7:0]  kc_q;
  cmd_t        map_cur, map_prev;
  key_state_t  state, state_nxt;
  logic        press;
  logic        issue, issue_press;
  cmd_t        issue_cmd;
  logic        tmr_clear, tmr_load, tmr_run, tmr_expire;
  logic [TW-1:0] tmr_limit;
  logic        out_valid, buf_valid, transfer;
  cmd_t        out_cmd, buf_cmd;

  assign map_cur = map_keycode(kc_q);
  assign press   = (map_cur != CMD_NONE) && (map_cur != map_prev);

  always_ff @(posedge clk) begin
    if (reset) begin
      kc_q     <= '0;
      map_prev <= CMD_NONE;
      state    <= ST_IDLE;
    end else begin
      kc_q     <= keycode;
      map_prev <= map_cur;
      state    <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tmr_clear   = 1'b0;
    tmr_load    = 1'b0;
    issue       = 1'b0;
    issue_press = 1'b0;
    issue_cmd   = map_cur;
    if (map_cur == CMD_NONE) begin
      state_nxt = ST_IDLE;
      tmr_clear = 1'b1;
    end else if (press) begin
      issue       = 1'b1;
      issue_press = 1'b1;
      tmr_load    = 1'b1;
      case (map_cur)
        CMD_LEFT, CMD_RIGHT: state_nxt = ST_DAS;
        CMD_SOFT:            state_nxt = ST_SOFTREP;
        default:             state_nxt = ST_HOLD;
      endcase
    end else if (tmr_expire) begin
      issue    = 1'b1;
      tmr_load = 1'b1;
      if (state == ST_DAS) state_nxt = ST_REPEAT;
    end
  end

  assign tmr_run = (state == ST_DAS) || (state == ST_REPEAT) || (state == ST_SOFTREP);

  always_comb begin
    case (state)
      ST_DAS:    tmr_limit = TW'(DAS_CYCLES);
      ST_REPEAT: tmr_limit = TW'(ARR_CYCLES);
      default:   tmr_limit = TW'(SOFT_CYCLES);
    endcase
  end

  das_timer #(.W(TW)) u_das_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .load   (tmr_load),
    .run    (tmr_run),
    .limit  (tmr_limit),
    .expire (tmr_expire)
  );

  assign transfer = out_valid && cmd_if.cmd_ready;

  // Repeats only ever land in an empty output; presses may wait in the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_cmd   <= CMD_NONE;
      buf_valid <= 1'b0;
      buf_cmd   <= CMD_NONE;
    end else if (!out_valid || transfer) begin
      if (buf_valid) begin
        out_valid <= 1'b1;
        out_cmd   <= buf_cmd;
        buf_valid <= issue_press;
        if (issue_press) buf_cmd <= issue_cmd;
      end else if (issue) begin
        out_valid <= 1'b1;
        out_cmd   <= issue_cmd;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (issue_press) begin
      buf_valid <= 1'b1;
      buf_cmd   <= issue_cmd;
    end
  end

  assign cmd_if.cmd_valid = out_valid;
  assign cmd_if.cmd       = out_cmd;
  assign held             = (state != ST_IDLE);
endmodule
